// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the 8-bit tri-state register bus initiator:
//   BUSW      - width of the shared register bus
//   op_e      - transfer command encodings carried on req_op
//   state_e   - transfer sequencer states
//   uses_src  - true when an op reads a source register
//   uses_dst  - true when an op writes or clears a destination register
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int BUSW = 8;

  typedef enum logic [1:0] {
    OP_MOV   = 2'd0,
    OP_CLR   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

  // MOV and STORE put a register on the bus.
  function automatic logic uses_src(input op_e op);
    return (op == OP_MOV) || (op == OP_STORE);
  endfunction

  // MOV, CLR and LOAD target a register.
  function automatic logic uses_dst(input op_e op);
    return (op != OP_STORE);
  endfunction

endpackage

// File: rtl/id_onehot_dec.sv
// ---------------------------------------------------------------------------
// id_onehot_dec
// Converts a binary register id into a one-hot select across NREG registers.
// Ports:
//   id     in  IDW   binary register id
//   en     in  1     decode enable; when low the output is all zeros
//   onehot out NREG  one-hot select (all zeros when disabled or out of range)
//   oor    out 1     enabled id addresses no register (id >= NREG)
// ---------------------------------------------------------------------------
module id_onehot_dec
  import bus_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IDW  = 3
) (
  input  logic [IDW-1:0]  id,
  input  logic            en,
  output logic [NREG-1:0] onehot,
  output logic            oor
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (id == IDW'(i));
    end
  end

  // An enabled id that selects nothing is by definition beyond NREG-1.
  assign oor = en && (onehot == '0);

endmodule

// File: rtl/bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl
// Initiator of the shared 8-bit tri-state register bus. Takes one transfer
// command at a time (MOV, CLR, LOAD, STORE) and sequences the per-register
// output enables, write enables and synchronous clears so that exactly one
// driver owns the bus, followed by a release/turnaround cycle.
//
// Sequence per command: IDLE/TURN --accept--> DRIVE -> LATCH -> TURN.
//   DRIVE : source on the bus (oa[src] or ext_din for LOAD)
//   LATCH : same driver plus wa[dst] / rclr[dst]; STORE captures the bus
//   TURN  : bus released, done pulse (err if the command was illegal)
//
// Ports:
//   clk        in   1     clock
//   clr        in   1     asynchronous active-high reset
//   req_valid  in   1     command valid
//   req_ready  out  1     command accepted on valid & ready at posedge
//   req_op     in   2     op_e encoding
//   req_src    in   IDW   source register id (MOV, STORE)
//   req_dst    in   IDW   destination register id (MOV, CLR, LOAD)
//   ext_din    in   8     external data for LOAD
//   bus        io   8     shared register bus, driven here only for LOAD
//   oa         out  NREG  one-hot register output enables
//   wa         out  NREG  one-hot register write enables
//   rclr       out  NREG  one-hot register synchronous clears
//   ext_dout   out  8     data captured by the last STORE
//   done       out  1     one-cycle completion pulse
//   err        out  1     with done: command was illegal and not executed
// ---------------------------------------------------------------------------
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [IDW-1:0]  req_src,
  input  logic [IDW-1:0]  req_dst,
  input  logic [BUSW-1:0] ext_din,
  inout  wire  [BUSW-1:0] bus,
  output logic [NREG-1:0] oa,
  output logic [NREG-1:0] wa,
  output logic [NREG-1:0] rclr,
  output logic [BUSW-1:0] ext_dout,
  output logic            done,
  output logic            err
);

  state_e          st_q;
  state_e          st_n;
  op_e             op_q;
  op_e             op_n;
  logic [IDW-1:0]  src_q;
  logic [IDW-1:0]  src_n;
  logic [IDW-1:0]  dst_q;
  logic [IDW-1:0]  dst_n;
  logic [BUSW-1:0] din_q;
  logic            drv_q;

  logic            accept;
  logic [NREG-1:0] src_oh;
  logic [NREG-1:0] dst_oh;
  logic            src_oor;
  logic            dst_oor;
  logic            ill_n;
  logic            xfer_n;
  logic [NREG-1:0] oa_n;
  logic [NREG-1:0] wa_n;
  logic [NREG-1:0] rclr_n;
  logic            drv_n;
  logic            store_cap;

  // req_ready is itself registered, so accept only depends on the current
  // state and req_valid; the strobes are a register stage further away.
  assign accept = req_valid && req_ready;

  // Next state and the command that will be in flight after this edge.
  always_comb begin
    st_n  = st_q;
    op_n  = op_q;
    src_n = src_q;
    dst_n = dst_q;
    case (st_q)
      ST_IDLE:  st_n = accept ? ST_DRIVE : ST_IDLE;
      ST_DRIVE: st_n = ST_LATCH;
      ST_LATCH: st_n = ST_TURN;
      ST_TURN:  st_n = accept ? ST_DRIVE : ST_IDLE;
      default:  st_n = ST_IDLE;
    endcase
    if (accept) begin
      op_n  = op_e'(req_op);
      src_n = req_src;
      dst_n = req_dst;
    end
  end

  // Unused fields are decoded with enable low, so they can neither select a
  // register nor flag an illegal command.
  id_onehot_dec #(.NREG(NREG), .IDW(IDW)) u_src_dec (
    .id     (src_n),
    .en     (uses_src(op_n)),
    .onehot (src_oh),
    .oor    (src_oor)
  );

  id_onehot_dec #(.NREG(NREG), .IDW(IDW)) u_dst_dec (
    .id     (dst_n),
    .en     (uses_dst(op_n)),
    .onehot (dst_oh),
    .oor    (dst_oor)
  );

  // Illegal commands still walk the full sequence with every strobe held off.
  assign ill_n = src_oor || dst_oor || ((op_n == OP_MOV) && (src_n == dst_n));

  // Strobe values for the state being entered, registered below.
  always_comb begin
    xfer_n = ((st_n == ST_DRIVE) || (st_n == ST_LATCH)) && !ill_n;
    oa_n   = '0;
    wa_n   = '0;
    rclr_n = '0;
    drv_n  = 1'b0;
    if (xfer_n) begin
      if (uses_src(op_n)) oa_n = src_oh;
      if (op_n == OP_LOAD) drv_n = 1'b1;
      if (st_n == ST_LATCH) begin
        if ((op_n == OP_MOV) || (op_n == OP_LOAD)) wa_n   = dst_oh;
        if (op_n == OP_CLR)                        rclr_n = dst_oh;
      end
    end
  end

  // A legal STORE in LATCH has its source enabled, so oa being non-zero is
  // exactly the condition for a valid bus value to capture.
  assign store_cap = (st_q == ST_LATCH) && (op_q == OP_STORE) && (oa != '0);

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_q      <= ST_IDLE;
      op_q      <= OP_MOV;
      src_q     <= '0;
      dst_q     <= '0;
      oa        <= '0;
      wa        <= '0;
      rclr      <= '0;
      drv_q     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
      ext_dout  <= '0;
    end else begin
      st_q      <= st_n;
      op_q      <= op_n;
      src_q     <= src_n;
      dst_q     <= dst_n;
      oa        <= oa_n;
      wa        <= wa_n;
      rclr      <= rclr_n;
      drv_q     <= drv_n;
      done      <= (st_n == ST_TURN);
      err       <= (st_n == ST_TURN) && ill_n;
      req_ready <= (st_n == ST_IDLE) || (st_n == ST_TURN);
      if (store_cap) ext_dout <= bus;
    end
  end

  // LOAD data is only visible on the bus while drv_q is set, so it needs no
  // reset.
  always_ff @(posedge clk) begin
    if (accept) din_q <= ext_din;
  end

  assign bus = drv_q ? din_q : {BUSW{1'bz}};

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Initiator side of the shared 8-bit tri-state register bus. The general-purpose registers are responders that obey per-register output enable (oa), write enable (wa) and synchronous clear (clr).
- Accepts one transfer command at a time: register move, register clear, external load or external store. Sequences the one-hot oa/wa/clr strobes so that exactly one driver owns the bus.
- Inserts a release/turnaround cycle after every transfer.
- Sits between the microcode sequencer and the register file.

Parameters:
- NREG, 8, number of registers on the bus (2..16).
- IDW, 3, width of register id fields; NREG <= 2**IDW.

Ports:
- clk  in  1  clock; all state changes on posedge.
- clr  in  1  asynchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when valid&ready at a posedge.
- req_op  in  2  0=MOV, 1=CLR, 2=LOAD (ext_din to dst), 3=STORE (src to ext_dout).
- req_src  in  IDW  source register id (used by MOV and STORE).
- req_dst  in  IDW  destination register id (used by MOV, CLR and LOAD).
- ext_din  in  8  external data, driven onto the bus for LOAD.
- bus  inout  8  shared register bus; driven only during LOAD.
- oa  out  NREG  one-hot per-register output enables.
- wa  out  NREG  one-hot per-register write enables.
- rclr  out  NREG  one-hot per-register synchronous clears.
- ext_dout  out  8  data captured by STORE; holds until the next STORE.
- done  out  1  one-cycle pulse marking transfer completion.
- err  out  1  valid with done; the command was illegal and was not executed.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE. oa, wa and rclr are all zero. bus is high-Z. ext_dout=0, done=0, err=0, req_ready=1.
- State machine: IDLE -> DRIVE -> LATCH -> TURN.
  - From TURN: go to DRIVE if a command is accepted, otherwise to IDLE.
  - req_ready=1 in IDLE and TURN only.
- All outputs are registered and decoded from the state plus the captured command. No combinational path exists from req_* to the strobes.
- DRIVE:
  - MOV/STORE: oa[src]=1.
  - LOAD: bus=ext_din (value captured at accept).
  - CLR: no strobes.
- LATCH:
  - Same driver as DRIVE, plus:
  - MOV/LOAD: wa[dst]=1.
  - CLR: rclr[dst]=1.
  - STORE: ext_dout <= bus value on the posedge that ends LATCH.
  - The destination register samples on that same edge.
- TURN:
  - All oa/wa/rclr are zero and bus is high-Z.
  - done=1 for this one cycle.
- Latency and throughput:
  - Command accepted at edge N: DRIVE in cycle N+1, LATCH in N+2, TURN/done in N+3.
  - Back-to-back commands complete every 3 cycles.
- Illegal command, checked at accept:
  - Any used id >= NREG, or MOV with src==dst.
  - The FSM still walks DRIVE/LATCH/TURN with every strobe suppressed.
  - done=1 and err=1 in TURN; ext_dout is unchanged.
- Fields not used by an op are ignored: src for CLR/LOAD, dst for STORE.
- At most one bit of oa is set, and at most one bit of wa|rclr is set, in every cycle.
- bus is never driven by this block while any oa bit is set.
- req_* are sampled only at the accept edge. Later changes have no effect on the command in flight.
- clr asserted mid-transfer: strobes drop immediately and the command is discarded, with no done. The destination is not written unless its own edge already occurred.

Decomposition:
- Shared package bus_pkg:
  - op encodings OP_MOV/OP_CLR/OP_LOAD/OP_STORE.
  - state encodings ST_IDLE/ST_DRIVE/ST_LATCH/ST_TURN.
  - bus width constant BUSW=8.
- One sub-module, id_onehot_dec: binary id plus enable in, NREG-bit one-hot out with an out-of-range flag. It is instantiated for src and for dst.

Test Plan:
- Reset in every state -> all strobes 0, bus=Z, req_ready=1 within the same cycle as clr rises.
- MOV src=2 dst=5, responder reg2=8'hA5:
  - oa=8'h04 in cycles N+1 and N+2.
  - wa=8'h20 in N+2.
  - reg5=8'hA5 after N+2.
  - done in N+3, err=0.
- LOAD dst=0 ext_din=8'h3C, then STORE src=0 issued back-to-back:
  - done pulses at N+3 and N+6.
  - ext_dout=8'h3C after N+5.
  - bus is Z in TURN.
- CLR dst=7 with reg7=8'hFF -> rclr=8'h80 in LATCH only; reg7=8'h00 afterwards.
- Illegal commands: MOV src=dst=3, and a NREG=6 build with LOAD dst=6 -> zero strobes throughout, done=1 with err=1, ext_dout unchanged.
- req_valid held high with 3 commands -> accepts at edges 0, 3 and 6. The one-hot and bus-ownership invariants are asserted every cycle.
